alu_reservation_station: RTL and testbench

Receiving end of the decode-to-ALU message channel. Buffers up to DEPTH AluInstr entries and snoops the completion bus to wake waiting operands. It issues the oldest instruction whose two sources are both valid to the ALU over a second message channel. It sits between the decode stage (upstream sender) and the ALU (downstream receiver).

---
 rtl/alu_reservation_station_pkg.sv | 41 ++++
 rtl/alu_reservation_station_source_wakeup.sv | 27 ++
 rtl/alu_reservation_station.sv | 156 +++++++++++++++
 tb/tb_alu_reservation_station.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_reservation_station_pkg
// Brief  : Message payload types shared by decode, reservation station, ALU.
// Rev    : 1.0
// ============================================================================
package alu_reservation_station_pkg;

   localparam int c_tag_w    = 6;
   localparam int c_data_w   = 32;
   localparam int c_commit_w = 5;
   localparam int c_logic_w  = 5;

   typedef struct packed {
      logic                valid;
      logic [c_tag_w-1:0]  tag;
      logic [c_data_w-1:0] data;
   } Source;

   typedef struct packed {
      logic [c_commit_w-1:0] commit_id;
      logic                  aux_op;
      logic [2:0]            funct3;
      logic [c_logic_w-1:0]  dest_logic;
      logic [c_tag_w-1:0]    dest_phys;
      Source                 src1;
      Source                 src2;
   } AluInstr;

   typedef struct packed {
      logic [1:0]          kind;
      logic [c_tag_w-1:0]  dest_phys;
      logic [c_data_w-1:0] data;
   } CompleteInfo;

   function automatic logic instr_ready(input AluInstr instr);
      return instr.src1.valid & instr.src2.valid;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_reservation_station_source_wakeup.sv
`default_nettype none
// ============================================================================
// Module : source_wakeup
// Brief  : Combinational completion-bus snoop for one operand.
// Rev    : 1.0
// ============================================================================
module source_wakeup
   import alu_reservation_station_pkg::*;
(
   input  Source       i_src,
   input  logic        i_cinfo_en,
   input  CompleteInfo i_cinfo,
   output Source       o_src
);

   always_comb begin
      o_src = i_src;
      // Only register-writeback completions (kind 0) carry operand data.
      if (!i_src.valid && i_cinfo_en && (i_cinfo.kind == 2'd0) &&
          (i_cinfo.dest_phys == i_src.tag)) begin
         o_src.valid = 1'b1;
         o_src.data  = i_cinfo.data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module : alu_reservation_station
// Brief  : Collapsing age-ordered ALU queue with operand wakeup; issues oldest ready.
// Rev    : 1.0
// ============================================================================
module alu_reservation_station
   import alu_reservation_station_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        flash,
   input  logic        alu_instr_en,
   output logic        alu_instr_reject,
   input  AluInstr     alu_instr_msg,
   input  logic        complete_info_en,
   input  CompleteInfo complete_info_msg,
   output logic        issue_en,
   input  logic        issue_reject,
   output AluInstr     issue_msg
);

   localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cnt_w = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]   r_valid;
   AluInstr            r_entry [DEPTH];
   logic [c_cnt_w-1:0] r_count;

   Source              w_src1_woken [DEPTH];
   Source              w_src2_woken [DEPTH];
   Source              w_in_src1;
   Source              w_in_src2;
   AluInstr            w_in;
   AluInstr            w_woken_ext [DEPTH+1];
   logic [DEPTH:0]     w_valid_ext;
   logic               w_any_ready;
   logic [c_idx_w-1:0] w_sel;
   logic               w_do_issue;
   logic               w_do_accept;
   logic [c_cnt_w-1:0] w_count_shift;
   logic [c_cnt_w-1:0] w_next_count;
   logic [DEPTH-1:0]   w_next_valid;
   AluInstr            w_next_entry [DEPTH];

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_slot
         source_wakeup u_src1 (
            .i_src      (r_entry[g].src1),
            .i_cinfo_en (complete_info_en),
            .i_cinfo    (complete_info_msg),
            .o_src      (w_src1_woken[g])
         );
         source_wakeup u_src2 (
            .i_src      (r_entry[g].src2),
            .i_cinfo_en (complete_info_en),
            .i_cinfo    (complete_info_msg),
            .o_src      (w_src2_woken[g])
         );
      end
   endgenerate

   source_wakeup u_in_src1 (
      .i_src      (alu_instr_msg.src1),
      .i_cinfo_en (complete_info_en),
      .i_cinfo    (complete_info_msg),
      .o_src      (w_in_src1)
   );
   source_wakeup u_in_src2 (
      .i_src      (alu_instr_msg.src2),
      .i_cinfo_en (complete_info_en),
      .i_cinfo    (complete_info_msg),
      .o_src      (w_in_src2)
   );

   // Extra all-invalid slot at the top lets the collapse shift in "empty".
   always_comb begin
      w_in      = alu_instr_msg;
      w_in.src1 = w_in_src1;
      w_in.src2 = w_in_src2;
      for (int i = 0; i < DEPTH; i++) begin
         w_woken_ext[i]      = r_entry[i];
         w_woken_ext[i].src1 = w_src1_woken[i];
         w_woken_ext[i].src2 = w_src2_woken[i];
      end
      w_woken_ext[DEPTH] = '0;
      w_valid_ext        = {1'b0, r_valid};
   end

   always_comb begin
      w_any_ready = 1'b0;
      w_sel       = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (r_valid[i] && instr_ready(r_entry[i])) begin
            w_any_ready = 1'b1;
            w_sel       = c_idx_w'(i);
         end
      end
   end

   assign alu_instr_reject = (r_count == c_cnt_w'(DEPTH));
   assign issue_en         = w_any_ready & ~flash;
   assign issue_msg        = r_entry[w_sel];
   assign w_do_issue       = issue_en & ~issue_reject;
   assign w_do_accept      = alu_instr_en & ~alu_instr_reject;

   always_comb begin
      w_next_valid = r_valid;
      for (int i = 0; i < DEPTH; i++) begin
         w_next_entry[i] = w_woken_ext[i];
      end
      if (w_do_issue) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i >= int'(w_sel)) begin
               w_next_valid[i] = w_valid_ext[i+1];
               w_next_entry[i] = w_woken_ext[i+1];
            end
         end
      end
      w_count_shift = r_count - {{(c_cnt_w-1){1'b0}}, w_do_issue};
      if (w_do_accept) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(w_count_shift)) begin
               w_next_valid[i] = 1'b1;
               w_next_entry[i] = w_in;
            end
         end
      end
      w_next_count = w_count_shift + {{(c_cnt_w-1){1'b0}}, w_do_accept};
   end

   always_ff @(posedge clock) begin
      if (reset || flash) begin
         r_valid <= '0;
         r_count <= '0;
      end else begin
         r_valid <= w_next_valid;
         r_count <= w_next_count;
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i] <= w_next_entry[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (r_count <= c_cnt_w'(DEPTH));
         assert (!(w_do_issue && (r_count == '0)));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_reservation_station
// Brief  : Directed self-checking bench for alu_reservation_station.
// Rev    : 1.0
// ============================================================================
module tb_alu_reservation_station;
   import alu_reservation_station_pkg::*;

   logic        clock;
   logic        reset;
   logic        flash;
   logic        alu_instr_en;
   logic        alu_instr_reject;
   AluInstr     alu_instr_msg;
   logic        complete_info_en;
   CompleteInfo complete_info_msg;
   logic        issue_en;
   logic        issue_reject;
   AluInstr     issue_msg;

   int checks = 0;
   int errors = 0;

   alu_reservation_station #(.DEPTH(4)) dut (
      .clock             (clock),
      .reset             (reset),
      .flash             (flash),
      .alu_instr_en      (alu_instr_en),
      .alu_instr_reject  (alu_instr_reject),
      .alu_instr_msg     (alu_instr_msg),
      .complete_info_en  (complete_info_en),
      .complete_info_msg (complete_info_msg),
      .issue_en          (issue_en),
      .issue_reject      (issue_reject),
      .issue_msg         (issue_msg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic AluInstr mk(input logic [4:0] id,
                                  input logic v1, input logic [5:0] t1, input logic [31:0] d1,
                                  input logic v2, input logic [5:0] t2, input logic [31:0] d2);
      AluInstr m;
      m            = '0;
      m.commit_id  = id;
      m.funct3     = 3'd2;
      m.dest_logic = id;
      m.dest_phys  = {1'b1, id};
      m.src1       = '{valid: v1, tag: t1, data: d1};
      m.src2       = '{valid: v2, tag: t2, data: d2};
      return m;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic complete(input logic [1:0] kind, input logic [5:0] tag, input logic [31:0] data);
      complete_info_en  = 1'b1;
      complete_info_msg = '{kind: kind, dest_phys: tag, data: data};
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (alu_instr_reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %b expected 0", alu_instr_reject); end
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL reset_issue_en: got %b expected 0", issue_en); end
      checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dut.r_count); end
      reset = 1'b0;
   endtask

   task automatic test_single_issue();
      alu_instr_msg = mk(5'd5, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h22);
      alu_instr_en  = 1'b1;
      #1;
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", issue_en); end
      step();
      alu_instr_en = 1'b0;
      #1;
      checks++; if (issue_en !== 1'b1) begin errors++; $display("FAIL single_issue_en: got %b expected 1", issue_en); end
      checks++; if (issue_msg.commit_id !== 5'd5) begin errors++; $display("FAIL single_commit: got %0d expected 5", issue_msg.commit_id); end
      checks++; if (issue_msg.dest_phys !== 6'h25) begin errors++; $display("FAIL single_dest_phys: got %0h expected 25", issue_msg.dest_phys); end
      step();
      checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL single_count: got %0d expected 0", dut.r_count); end
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", issue_en); end
   endtask

   task automatic test_wakeup();
      alu_instr_msg = mk(5'd1, 1'b0, 6'd7, 32'h0, 1'b1, 6'd0, 32'h2);
      alu_instr_en  = 1'b1;
      step();
      alu_instr_en = 1'b0;
      #1;
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL wake_waiting: got %b expected 0", issue_en); end
      step();
      complete(2'd0, 6'd7, 32'h1234);
      #1;
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL wake_no_comb_path: got %b expected 0", issue_en); end
      step();
      complete_info_en = 1'b0;
      #1;
      checks++; if (issue_en !== 1'b1) begin errors++; $display("FAIL wake_issue_en: got %b expected 1", issue_en); end
      checks++; if (issue_msg.src1.data !== 32'h1234) begin errors++; $display("FAIL wake_src1_data: got %0h expected 1234", issue_msg.src1.data); end
      checks++; if (issue_msg.commit_id !== 5'd1) begin errors++; $display("FAIL wake_commit: got %0d expected 1", issue_msg.commit_id); end
      step();
      checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL wake_count: got %0d expected 0", dut.r_count); end
   endtask

   task automatic test_kind_filter();
      alu_instr_msg = mk(5'd2, 1'b0, 6'd3, 32'h0, 1'b1, 6'd3, 32'h55);
      alu_instr_en  = 1'b1;
      step();
      alu_instr_en = 1'b0;
      complete(2'd1, 6'd3, 32'h99);
      step();
      complete_info_en = 1'b0;
      #1;
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL kind_ignored: got %b expected 0", issue_en); end
      complete(2'd0, 6'd3, 32'h99);
      step();
      complete_info_en = 1'b0;
      #1;
      checks++; if (issue_en !== 1'b1) begin errors++; $display("FAIL kind0_wakes: got %b expected 1", issue_en); end
      checks++; if (issue_msg.src1.data !== 32'h99) begin errors++; $display("FAIL kind_src1_data: got %0h expected 99", issue_msg.src1.data); end
      checks++; if (issue_msg.src2.data !== 32'h55) begin errors++; $display("FAIL valid_src_kept: got %0h expected 55", issue_msg.src2.data); end
      step();
      checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL kind_count: got %0d expected 0", dut.r_count); end
   endtask

   task automatic test_fill_wake();
      for (int k = 0; k < 4; k++) begin
         alu_instr_msg = mk(5'(10 + k), 1'b0, 6'(20 + k), 32'h0, 1'b1, 6'd0, 32'h7);
         alu_instr_en  = 1'b1;
         step();
      end
      alu_instr_en = 1'b0;
      #1;
      checks++; if (alu_instr_reject !== 1'b1) begin errors++; $display("FAIL fill_reject: got %b expected 1", alu_instr_reject); end
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL fill_unready: got %b expected 0", issue_en); end
      complete(2'd0, 6'd22, 32'hA2);
      step();
      complete_info_en = 1'b0;
      #1;
      checks++; if (issue_en !== 1'b1) begin errors++; $display("FAIL fill_issue_en: got %b expected 1", issue_en); end
      checks++; if (issue_msg.commit_id !== 5'd12) begin errors++; $display("FAIL fill_first_commit: got %0d expected 12", issue_msg.commit_id); end
      checks++; if (alu_instr_reject !== 1'b1) begin errors++; $display("FAIL full_issue_reject: got %b expected 1", alu_instr_reject); end
      // A ready instruction offered while full-and-issuing must be dropped.
      alu_instr_msg = mk(5'd30, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
      alu_instr_en  = 1'b1;
      step();
      alu_instr_en = 1'b0;
      #1;
      checks++; if (dut.r_count !== 3'd3) begin errors++; $display("FAIL fill_count3: got %0d expected 3", dut.r_count); end
      checks++; if (alu_instr_reject !== 1'b0) begin errors++; $display("FAIL fill_reject_drop: got %b expected 0", alu_instr_reject); end
      issue_reject = 1'b1;
      complete(2'd0, 6'd23, 32'hA3);
      step();
      complete(2'd0, 6'd21, 32'hA1);
      step();
      complete(2'd0, 6'd20, 32'hA0);
      step();
      complete_info_en = 1'b0;
      #1;
      checks++; if (issue_msg.commit_id !== 5'd10) begin errors++; $display("FAIL order_0: got %0d expected 10", issue_msg.commit_id); end
      issue_reject = 1'b0;
      step();
      checks++; if (issue_msg.commit_id !== 5'd11) begin errors++; $display("FAIL order_1: got %0d expected 11", issue_msg.commit_id); end
      step();
      checks++; if (issue_msg.commit_id !== 5'd13) begin errors++; $display("FAIL order_2: got %0d expected 13", issue_msg.commit_id); end
      checks++; if (issue_msg.src1.data !== 32'hA3) begin errors++; $display("FAIL order_2_data: got %0h expected a3", issue_msg.src1.data); end
      step();
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL fill_drained: got %b expected 0", issue_en); end
      checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL fill_count0: got %0d expected 0", dut.r_count); end
   endtask

   task automatic test_accept_snoop();
      alu_instr_msg = mk(5'd3, 1'b1, 6'd0, 32'h1, 1'b0, 6'd9, 32'h0);
      alu_instr_en  = 1'b1;
      complete(2'd0, 6'd9, 32'hABCD);
      step();
      alu_instr_en     = 1'b0;
      complete_info_en = 1'b0;
      #1;
      checks++; if (issue_en !== 1'b1) begin errors++; $display("FAIL snoop_issue_en: got %b expected 1", issue_en); end
      checks++; if (issue_msg.src2.valid !== 1'b1) begin errors++; $display("FAIL snoop_src2_valid: got %b expected 1", issue_msg.src2.valid); end
      checks++; if (issue_msg.src2.data !== 32'hABCD) begin errors++; $display("FAIL snoop_src2_data: got %0h expected abcd", issue_msg.src2.data); end
      step();
      checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL snoop_count: got %0d expected 0", dut.r_count); end
   endtask

   task automatic test_issue_reject();
      alu_instr_msg = mk(5'd6, 1'b1, 6'd0, 32'h6, 1'b1, 6'd0, 32'h66);
      alu_instr_en  = 1'b1;
      step();
      alu_instr_en = 1'b0;
      issue_reject = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (issue_en !== 1'b1) begin errors++; $display("FAIL hold_en[%0d]: got %b expected 1", k, issue_en); end
         checks++; if (issue_msg.commit_id !== 5'd6) begin errors++; $display("FAIL hold_commit[%0d]: got %0d expected 6", k, issue_msg.commit_id); end
         checks++; if (dut.r_count !== 3'd1) begin errors++; $display("FAIL hold_count[%0d]: got %0d expected 1", k, dut.r_count); end
         step();
      end
      issue_reject = 1'b0;
      #1;
      checks++; if (issue_en !== 1'b1) begin errors++; $display("FAIL release_en: got %b expected 1", issue_en); end
      step();
      checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL release_count: got %0d expected 0", dut.r_count); end
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL release_once: got %b expected 0", issue_en); end
   endtask

   task automatic test_flash();
      issue_reject  = 1'b1;
      alu_instr_en  = 1'b1;
      alu_instr_msg = mk(5'd14, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
      step();
      alu_instr_msg = mk(5'd15, 1'b0, 6'd30, 32'h0, 1'b1, 6'd0, 32'h0);
      step();
      alu_instr_msg = mk(5'd16, 1'b0, 6'd31, 32'h0, 1'b1, 6'd0, 32'h0);
      step();
      alu_instr_en = 1'b0;
      #1;
      checks++; if (dut.r_count !== 3'd3) begin errors++; $display("FAIL flash_pre_count: got %0d expected 3", dut.r_count); end
      checks++; if (issue_en !== 1'b1) begin errors++; $display("FAIL flash_pre_en: got %b expected 1", issue_en); end
      flash         = 1'b1;
      alu_instr_en  = 1'b1;
      alu_instr_msg = mk(5'd17, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
      #1;
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL flash_forces_en: got %b expected 0", issue_en); end
      step();
      flash        = 1'b0;
      alu_instr_en = 1'b0;
      issue_reject = 1'b0;
      #1;
      checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL flash_count: got %0d expected 0", dut.r_count); end
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL flash_issue_en: got %b expected 0", issue_en); end
      checks++; if (alu_instr_reject !== 1'b0) begin errors++; $display("FAIL flash_reject: got %b expected 0", alu_instr_reject); end
      step();
      step();
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL flash_never_issues: got %b expected 0", issue_en); end
   endtask

   initial begin
      reset             = 1'b1;
      flash             = 1'b0;
      alu_instr_en      = 1'b0;
      alu_instr_msg     = '0;
      complete_info_en  = 1'b0;
      complete_info_msg = '0;
      issue_reject      = 1'b0;
      test_reset();
      test_single_issue();
      test_wakeup();
      test_kind_filter();
      test_fill_wake();
      test_accept_snoop();
      test_issue_reject();
      test_flash();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
